// File: rtl/logit_result_buffer_if.sv
// Dense-output handshake bundle between the logit producer/requester
// and the logit result buffer.
interface logit_result_buffer_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 32
);
  logic              start;
  logic              wr_valid;
  logic [3:0]        wr_index;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;
  logic [ADDR_W-1:0] read_addr;
  logic [DATA_W-1:0] read_data;
  logic              done;
  logic              busy;
  logic              err_index;
  logic [3:0]        fill_count;

  modport master (
    output start, wr_valid, wr_index, wr_data, read_addr,
    input  wr_ready, read_data, done, busy, err_index, fill_count
  );

  modport slave (
    input  start, wr_valid, wr_index, wr_data, read_addr,
    output wr_ready, read_data, done, busy, err_index, fill_count
  );
endinterface

// File: rtl/logit_result_buffer.sv
// Logit result buffer: clears, collects NUM_CLASSES signed logits, pulses done.
// Optional macro RESULT_READ_REG_EN: registered read path, done delayed 1 cycle.
module logit_result_buffer #(
  parameter int DATA_W      = 64,
  parameter int NUM_CLASSES = 10,
  parameter int ADDR_W      = 32,
  parameter int ADDR_STRIDE = 16
) (
  input logic clk,
  input logic reset,
  logit_result_buffer_if.slave bus
);

  localparam int SHIFT = $clog2(ADDR_STRIDE);
  localparam int IDX_W = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    COLLECT,
    DONE
  } state_t;

  state_t state;

  logic [DATA_W-1:0]      mem [NUM_CLASSES];
  logic [NUM_CLASSES-1:0] mask;
  logic [3:0]             fill_q;
  logic                   done_q;
  logic                   busy_q;
  logic                   ready_q;
  logic                   err_q;

`ifdef RESULT_READ_REG_EN
  logic hold_q;
`endif

  logic                   idx_ok;
  logic [NUM_CLASSES-1:0] set_bit;
  logic [NUM_CLASSES-1:0] next_mask;

  logic              aligned;
  logic [ADDR_W-1:0] slot;
  logic              hit;
  logic [DATA_W-1:0] rd_comb;

  // Write-side decode: legal index and the mask after this write.
  always_comb begin
    idx_ok  = 32'(bus.wr_index) < NUM_CLASSES;
    set_bit = '0;
    if (idx_ok) begin
      set_bit[bus.wr_index] = 1'b1;
    end
    next_mask = mask | set_bit;
  end

  // Read-side decode: aligned, in-range addresses hit an entry.
  always_comb begin
    aligned = (bus.read_addr & ADDR_W'(ADDR_STRIDE - 1)) == '0;
    slot    = bus.read_addr >> SHIFT;
    hit     = aligned && (slot < ADDR_W'(NUM_CLASSES));
    rd_comb = '0;
    if (hit) begin
      rd_comb = mem[slot[IDX_W-1:0]];
    end
  end

  // Control FSM with registered status outputs and entry storage.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      mask    <= '0;
      fill_q  <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
`ifdef RESULT_READ_REG_EN
      hold_q  <= 1'b0;
`endif
      for (int i = 0; i < NUM_CLASSES; i++) begin
        mem[i] <= '0;
      end
    end else begin
      unique case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            state   <= CLEAR;
            busy_q  <= 1'b1;
            ready_q <= 1'b0;
          end
        end
        CLEAR: begin
          for (int i = 0; i < NUM_CLASSES; i++) begin
            mem[i] <= '0;
          end
          mask    <= '0;
          fill_q  <= '0;
          err_q   <= 1'b0;
          state   <= COLLECT;
          busy_q  <= 1'b1;
          ready_q <= 1'b1;
        end
        COLLECT: begin
          if (bus.wr_valid && idx_ok) begin
            mem[bus.wr_index] <= bus.wr_data;
            if (!mask[bus.wr_index]) begin
              mask   <= next_mask;
              fill_q <= fill_q + 4'd1;
            end
            if (&next_mask) begin
              state   <= DONE;
              busy_q  <= 1'b0;
              ready_q <= 1'b0;
`ifdef RESULT_READ_REG_EN
              done_q  <= 1'b0;
              hold_q  <= 1'b0;
`else
              done_q  <= 1'b1;
`endif
            end
          end else if (bus.wr_valid) begin
            err_q <= 1'b1;
          end
        end
        DONE: begin
`ifdef RESULT_READ_REG_EN
          if (!hold_q) begin
            hold_q <= 1'b1;
            done_q <= 1'b1;
          end else begin
            hold_q <= 1'b0;
            done_q <= 1'b0;
            state  <= IDLE;
          end
`else
          done_q <= 1'b0;
          state  <= IDLE;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef RESULT_READ_REG_EN
  logic [DATA_W-1:0] rd_q;

  // Registered read: previous-cycle address, same decode rules.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q <= '0;
    end else begin
      rd_q <= rd_comb;
    end
  end

  assign bus.read_data = rd_q;
`else
  assign bus.read_data = rd_comb;
`endif

  assign bus.done       = done_q;
  assign bus.busy       = busy_q;
  assign bus.wr_ready   = ready_q;
  assign bus.err_index  = err_q;
  assign bus.fill_count = fill_q;

endmodule

// File: tb/tb_logit_result_buffer.sv
// Directed bench for logit_result_buffer (default build).
// Drives after #1 past posedge, samples at the same point.
module tb_logit_result_buffer;

  logic clk;
  logic reset;
  int   errors;
  int   checks;
  int   dcount;

  logit_result_buffer_if #(.DATA_W(64), .ADDR_W(32)) bus ();

  logit_result_buffer #(
    .DATA_W(64),
    .NUM_CLASSES(10),
    .ADDR_W(32),
    .ADDR_STRIDE(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int seq2 [11] = '{9, 3, 3, 0, 1, 2, 4, 5, 6, 7, 8};
  int fil2 [11] = '{1, 2, 2, 3, 4, 5, 6, 7, 8, 9, 10};

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (bus.done) dcount++;
  endtask

  task automatic rd(input logic [31:0] a);
    bus.read_addr = a;
    #1;
  endtask

  task automatic begin_collect();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
  endtask

  initial begin
    longint d;
    int dbase;
    int clears;
    errors = 0;
    checks = 0;
    dcount = 0;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.wr_valid = 1'b0;
    bus.wr_index = '0;
    bus.wr_data = '0;
    bus.read_addr = '0;
    step();
    step();
    dcount = 0;

    // reset state
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_ready", 64'(bus.wr_ready), 64'd0);
    chk("rst_err", 64'(bus.err_index), 64'd0);
    chk("rst_fill", 64'(bus.fill_count), 64'd0);
    chk("rst_rd0", bus.read_data, 64'd0);
    reset = 1'b0;

    // test 1: in-order collection
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("t1_clear_busy", 64'(bus.busy), 64'd1);
    chk("t1_clear_ready", 64'(bus.wr_ready), 64'd0);
    step();
    chk("t1_coll_ready", 64'(bus.wr_ready), 64'd1);
    for (int k = 0; k < 10; k++) begin
      bus.wr_valid = 1'b1;
      bus.wr_index = 4'(k);
      bus.wr_data = 64'(k * 100 - 500);
      step();
      chk($sformatf("t1_done_%0d", k), 64'(bus.done),
          64'(k == 9));
    end
    bus.wr_valid = 1'b0;
    chk("t1_fill", 64'(bus.fill_count), 64'd10);
    step();
    chk("t1_done_off", 64'(bus.done), 64'd0);
    chk("t1_dcount", 64'(dcount), 64'd1);
    for (int k = 0; k < 10; k++) begin
      rd(32'(k * 16));
      d = longint'(k * 100 - 500);
      chk($sformatf("t1_rd_%0d", k), bus.read_data, 64'(d));
    end

    // test 2: out of order with overwrite
    begin_collect();
    for (int i = 0; i < 11; i++) begin
      bus.wr_valid = 1'b1;
      bus.wr_index = 4'(seq2[i]);
      if (i == 2) bus.wr_data = 64'h7FFF_FFFF_FFFF_FFFF;
      else bus.wr_data = 64'(seq2[i] * 7 + 1);
      step();
      chk($sformatf("t2_fill_%0d", i), 64'(bus.fill_count),
          64'(fil2[i]));
      chk($sformatf("t2_done_%0d", i), 64'(bus.done),
          64'(i == 10));
    end
    bus.wr_valid = 1'b0;
    step();
    rd(32'd48);
    chk("t2_rd48", bus.read_data, 64'h7FFF_FFFF_FFFF_FFFF);
    rd(32'd0);
    chk("t2_rd0", bus.read_data, 64'd1);
    rd(32'd144);
    chk("t2_rd144", bus.read_data, 64'd64);

    // test 4: unaligned / out-of-range reads
    rd(32'd8);
    chk("t4_rd8", bus.read_data, 64'd0);
    rd(32'd160);
    chk("t4_rd160", bus.read_data, 64'd0);
    rd(32'hFFFF_FFF0);
    chk("t4_rdhi", bus.read_data, 64'd0);

    // test 3: out-of-range write index
    begin_collect();
    bus.wr_valid = 1'b1;
    bus.wr_index = 4'd0;
    bus.wr_data = 64'd11;
    step();
    bus.wr_index = 4'd12;
    bus.wr_data = 64'd5;
    step();
    bus.wr_valid = 1'b0;
    chk("t3_err", 64'(bus.err_index), 64'd1);
    chk("t3_fill", 64'(bus.fill_count), 64'd1);
    rd(32'd0);
    chk("t3_rd0", bus.read_data, 64'd11);
    rd(32'd16);
    chk("t3_rd16", bus.read_data, 64'd0);
    for (int k = 1; k < 10; k++) begin
      bus.wr_valid = 1'b1;
      bus.wr_index = 4'(k);
      bus.wr_data = 64'(k);
      step();
    end
    bus.wr_valid = 1'b0;
    chk("t3_done", 64'(bus.done), 64'd1);
    chk("t3_err_sticky", 64'(bus.err_index), 64'd1);
    step();
    begin_collect();
    chk("t3_err_clr", 64'(bus.err_index), 64'd0);
    rd(32'd0);
    chk("t3_rd0_clr", bus.read_data, 64'd0);

    // test 5: reset mid-collection
    for (int k = 0; k < 5; k++) begin
      bus.wr_valid = 1'b1;
      bus.wr_index = 4'(k);
      bus.wr_data = 64'(1000 + k);
      step();
    end
    bus.wr_valid = 1'b0;
    chk("t5_fill5", 64'(bus.fill_count), 64'd5);
    dbase = dcount;
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t5_busy", 64'(bus.busy), 64'd0);
    chk("t5_fill", 64'(bus.fill_count), 64'd0);
    chk("t5_ready", 64'(bus.wr_ready), 64'd0);
    rd(32'd0);
    chk("t5_rd0", bus.read_data, 64'd0);
    bus.wr_valid = 1'b1;
    bus.wr_index = 4'd12;
    bus.wr_data = 64'd5;
    step();
    bus.wr_valid = 1'b0;
    step();
    chk("t5_idle_err", 64'(bus.err_index), 64'd0);
    chk("t5_idle_fill", 64'(bus.fill_count), 64'd0);
    chk("t5_nodone", 64'(dcount - dbase), 64'd0);

    // test 6: start held three cycles
    begin_collect();
    for (int k = 0; k < 10; k++) begin
      bus.wr_valid = 1'b1;
      bus.wr_index = 4'(k);
      bus.wr_data = 64'(k + 20);
      step();
    end
    bus.wr_valid = 1'b0;
    step();
    rd(32'd32);
    chk("t6_idle_keep", bus.read_data, 64'd22);
    dbase = dcount;
    clears = 0;
    bus.start = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      if (bus.busy && !bus.wr_ready) clears++;
      if (c == 0) chk("t6_clear_keep", bus.read_data, 64'd22);
    end
    bus.start = 1'b0;
    chk("t6_clears", 64'(clears), 64'd1);
    chk("t6_rd32_zero", bus.read_data, 64'd0);
    chk("t6_fill0", 64'(bus.fill_count), 64'd0);
    for (int k = 0; k < 10; k++) begin
      bus.wr_valid = 1'b1;
      bus.wr_index = 4'(k);
      bus.wr_data = 64'(k - 3);
      step();
    end
    bus.wr_valid = 1'b0;
    step();
    step();
    step();
    chk("t6_dcount", 64'(dcount - dbase), 64'd1);
    rd(32'd0);
    chk("t6_rd0", bus.read_data, 64'hFFFF_FFFF_FFFF_FFFD);
    rd(32'd144);
    chk("t6_rd144", bus.read_data, 64'd6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/logit_result_buffer.md
Name: logit_result_buffer

Overview:
- Responder side of the dense-output read interface used by the MNIST CNN accelerator engine.
- Accepts a start pulse and clears its storage, then collects NUM_CLASSES signed logits streamed from the dense-layer datapath.
- Pulses done when all logits are present, then serves byte-addressed reads, one entry every ADDR_STRIDE bytes, so the requester can fill its output buffer and run argmax.

Parameters:
- DATA_W, 64: logit width, signed two's complement.
- NUM_CLASSES, 10: number of logit entries.
- ADDR_W, 32: read address width.
- ADDR_STRIDE, 16: byte distance between consecutive entries; must be a power of two.

Ports:
- clk  input  1: clock; all logic on posedge.
- reset  input  1: synchronous, active-high reset.
- start  input  1: one-cycle request to begin a new collection.
- wr_valid  input  1: producer presents a logit this cycle.
- wr_index  input  4: class index of the presented logit.
- wr_data  input  DATA_W: signed logit value.
- wr_ready  output  1: high while logits are accepted (COLLECT state).
- read_addr  input  ADDR_W: byte address of the requested entry.
- read_data  output  DATA_W: addressed entry.
- done  output  1: one-cycle pulse when all NUM_CLASSES entries are written.
- busy  output  1: high in CLEAR and COLLECT.
- err_index  output  1: sticky flag; an out-of-range wr_index was offered.
- fill_count  output  4: number of distinct entries written since the last start.

Behaviour:
- Reset (sync, active-high):
  - state=IDLE; all entries=0; valid mask=0; fill_count=0.
  - done=0, busy=0, wr_ready=0, err_index=0.
  - Reset has priority over every other input, including mid-collection; the partial collection is discarded.
- States: IDLE, CLEAR, COLLECT, DONE.
  - IDLE: start=1 -> CLEAR. Entries are retained and stay readable.
  - CLEAR, one cycle:
    - zero all entries, valid mask, fill_count and err_index;
    - busy=1, wr_ready=0;
    - next state COLLECT unconditionally.
  - COLLECT: wr_ready=1, busy=1. A write is accepted when wr_valid=1 and wr_index<NUM_CLASSES.
    - New index: store wr_data, set its mask bit, fill_count+1.
    - Index already written: overwrite the data; mask and fill_count are unchanged.
    - wr_index>=NUM_CLASSES: write is dropped, err_index<=1 (sticky until the next CLEAR or reset).
    - Transition to DONE on the cycle after the accepted write that completes the mask.
  - DONE, one cycle: done=1, busy=0, wr_ready=0; next state IDLE.
- Latency:
  - start to wr_ready is 2 cycles (CLEAR, then COLLECT).
  - The last accepted write to the done pulse is 1 cycle.
  - The minimum total from start to done is 12 cycles, with back-to-back writes.
- start is ignored in CLEAR, COLLECT and DONE. The requester must wait for done before restarting.
- wr_valid is ignored outside COLLECT; it sets no error.
- Read, combinational: read_data = entry[read_addr / ADDR_STRIDE] when both hold:
  - read_addr % ADDR_STRIDE == 0;
  - read_addr / ADDR_STRIDE < NUM_CLASSES.
  Otherwise read_data=0.
- Reads are legal in every state.
  - During COLLECT they return partial or zeroed data.
  - A same-cycle write and read of one entry returns the old value; the new value is visible the next cycle.
- Arithmetic: storage is a full DATA_W copy, with no truncation or sign change. fill_count saturates at NUM_CLASSES by construction.

Optional Feature:
- RESULT_READ_REG_EN
- Defined: read_data is registered.
  - It reflects the read_addr from the previous cycle, with the same decode and zero rules.
  - Reset value is 0.
  - The done pulse is delayed one extra cycle (DONE held 2 cycles, done high only in the second), so the first registered read after done is coherent.
- Undefined: combinational read path and done timing exactly as in Behaviour.

Test Plan:
- Reset, start, then writes of index 0..9 with data k*100-500, one per cycle.
  - Response: done pulses exactly once, 1 cycle after the index-9 write.
  - Reads at addr 0,16,...,144 return -500,-400,...,400.
- Writes in order 9,3,3,0,1,2,4,5,6,7,8, with the second index-3 write carrying 0x7FFF_FFFF_FFFF_FFFF.
  - Response: fill_count never exceeds 10; done after the 11th write.
  - addr 48 returns 0x7FFF_FFFF_FFFF_FFFF.
- wr_index=12 with data 5 offered during COLLECT.
  - Response: err_index=1, no entry changes, fill_count unchanged.
  - A subsequent start clears err_index to 0.
- Reads at addr 8, 160 and 0xFFFF_FFF0.
  - Response: read_data=0 in each case.
- reset asserted after 5 accepted writes.
  - Response: next cycle state=IDLE, busy=0, fill_count=0; addr 0 reads 0; no done pulse.
- start held high for 3 cycles, then a normal full collection.
  - Response: exactly one CLEAR, exactly one done.
  - Data from the previous collection stays readable in IDLE until the new CLEAR.
